ft2232h_tx_arbiter: RTL and testbench

Shares the FT2232H synchronous-FIFO transmit path between NUM_CH byte-stream requesters. Arbitration is round-robin and works at packet granularity. Each granted packet is framed as a header byte, a length byte, then the payload. The block sits between the on-chip data producers and the FT2232H TXE#/WR#/D[7:0] pins, and owns the single-byte output holding register that absorbs TXE# deassertion mid-burst.

---
 rtl/ft2232h_pkg.sv | 9 +
 rtl/ft2232h_tx_arbiter_rr.sv | 29 ++
 rtl/ft2232h_tx_arbiter.sv | 116 +++++++++++
 tb/tb_ft2232h_tx_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ft2232h_pkg.sv
// ft2232h_pkg: shared state encoding, channel id width and header-byte helper for the FT2232H transmit arbiter
package ft2232h_pkg;
  localparam int CH_W = 2;
  localparam logic [3:0] HDR_TAG_DEF = 4'hA;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, LEN = 2'd2, DATA = 2'd3} state_e;
  function automatic logic [7:0] hdr_byte(input logic [3:0] tag, input logic [CH_W-1:0] ch);
    return {tag, 2'b00, ch};
  endfunction
endpackage

// File: rtl/ft2232h_tx_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting just after the last-served channel
module rr_arbiter
  import ft2232h_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o
);
  logic [CH_W-1:0] c;
  logic found;
  // scan from ptr+1 upward with wrap; the last-served channel is looked at last
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = CH_W'((int'(ptr_i) + i) % NUM_CH);
      if (!found && req_i[c]) begin
        gnt_o[c] = 1'b1;
        idx_o = c;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ft2232h_tx_arbiter.sv
// ft2232h_tx_arbiter: packet-granular round-robin sharing of the FT2232H sync-FIFO transmit path
module ft2232h_tx_arbiter
  import ft2232h_pkg::*;
#(
  parameter int         NUM_CH  = 4,
  parameter logic [3:0] HDR_TAG = HDR_TAG_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                txe_n,
  output logic                wr_n,
  output logic [7:0]          data_out,
  input  logic [NUM_CH-1:0]   req,
  input  logic [8*NUM_CH-1:0] req_len,
  input  logic [8*NUM_CH-1:0] s_data,
  input  logic [NUM_CH-1:0]   s_valid,
  output logic [NUM_CH-1:0]   s_ready,
  output logic [NUM_CH-1:0]   grant,
  output logic                busy,
  output logic                pkt_done
);
  state_e state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d, pick;
  logic [CH_W-1:0] ch_q, ch_d, ptr_q, ptr_d, pick_idx;
  logic [7:0] rem_q, rem_d, data_q, data_d;
  logic hold_valid_q, hold_valid_d, pkt_done_q, pkt_done_d;
  logic slot_free;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(pick),
    .idx_o(pick_idx)
  );

  // holding slot is free when empty or when its byte is being written this edge
  assign slot_free = ~hold_valid_q | ~txe_n;
  assign wr_n = ~(hold_valid_q & ~txe_n);
  assign data_out = data_q;
  assign grant = grant_q;
  assign busy = state_q != IDLE;
  assign pkt_done = pkt_done_q;

  // state and holding register; async reset drops wr_n immediately and abandons any partial packet
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ch_q <= '0;
      ptr_q <= CH_W'(NUM_CH - 1);
      rem_q <= '0;
      data_q <= 8'h00;
      hold_valid_q <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ch_q <= ch_d;
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      data_q <= data_d;
      hold_valid_q <= hold_valid_d;
      pkt_done_q <= pkt_done_d;
    end

  // framing sequence header, length, payload; every load happens only into a free slot
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ch_d = ch_q;
    ptr_d = ptr_q;
    rem_d = rem_q;
    data_d = data_q;
    hold_valid_d = hold_valid_q & ~slot_free;
    pkt_done_d = 1'b0;
    s_ready = '0;
    unique case (state_q)
      IDLE: if (|req) begin
        grant_d = pick;
        ch_d = pick_idx;
        rem_d = req_len[pick_idx*8 +: 8];
        state_d = HDR;
      end
      HDR: if (slot_free) begin
        hold_valid_d = 1'b1;
        data_d = hdr_byte(HDR_TAG, ch_q);
        state_d = LEN;
      end
      LEN: if (slot_free) begin
        hold_valid_d = 1'b1;
        data_d = rem_q;
        state_d = rem_q == 8'd0 ? IDLE : DATA;
        if (rem_q == 8'd0) begin
          pkt_done_d = 1'b1;
          grant_d = '0;
          ptr_d = ch_q;
        end
      end
      DATA: begin
        s_ready[ch_q] = slot_free;
        if (s_valid[ch_q] && slot_free) begin
          hold_valid_d = 1'b1;
          data_d = s_data[ch_q*8 +: 8];
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            pkt_done_d = 1'b1;
            grant_d = '0;
            ptr_d = ch_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ft2232h_tx_arbiter.sv
// tb_ft2232h_tx_arbiter: directed scoreboard bench for the FT2232H transmit arbiter
module tb_ft2232h_tx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, reset = 1'b1, txe_n = 1'b0;
  logic wr_n, busy, pkt_done;
  logic [7:0] data_out;
  logic [N-1:0] req = '0, s_valid, s_ready, grant, sv_en = '1, grant_p = '0;
  logic [8*N-1:0] req_len = '0, s_data;
  logic [7:0] pay [N][16];
  int idx [N] = '{default: 0};
  int gcnt [N] = '{default: 0};
  int g0 [N];
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  int n_cmp = 0, n_bad = 0, wr_cnt = 0, rdy_cnt = 0;

  always #8 clk = ~clk;

  ft2232h_tx_arbiter #(.NUM_CH(N), .HDR_TAG(4'hA)) dut (
    .clk(clk), .reset(reset), .txe_n(txe_n), .wr_n(wr_n), .data_out(data_out),
    .req(req), .req_len(req_len), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .grant(grant), .busy(busy), .pkt_done(pkt_done)
  );

  assign s_valid = sv_en;
  always_comb for (int c = 0; c < N; c++) s_data[c*8 +: 8] = pay[c][idx[c][3:0]];

  always @(posedge clk)
    for (int c = 0; c < N; c++) if (s_valid[c] && s_ready[c]) idx[c] <= idx[c] + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every byte written to the FIFO must be the next scoreboard entry
  always @(negedge clk) begin
    if (!wr_n) begin
      wr_cnt++;
      exp_b = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      chk("sb_byte", {24'h0, data_out}, {24'h0, exp_b});
    end
    for (int c = 0; c < N; c++) if (grant[c] && !grant_p[c]) gcnt[c]++;
    grant_p = grant;
    rdy_cnt += int'(s_ready[2]);
  end

  task automatic push_pkt(input int c, input logic [7:0] len, input logic [7:0] base, input logic [7:0] step);
    req_len[c*8 +: 8] = len;
    exp_q.push_back({4'hA, 2'b00, 2'(c)});
    exp_q.push_back(len);
    for (int i = 0; i < int'(len); i++) begin
      pay[c][(idx[c] + i) % 16] = base + 8'(i) * step;
      exp_q.push_back(base + 8'(i) * step);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && !pkt_done; i++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, {31'h0, pkt_done}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w0, r0, run, mrun, pd;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_n", {31'h0, wr_n}, 1);
    chk("rst_data", {24'h0, data_out}, 0);
    chk("rst_grant", {28'h0, grant}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, pkt_done}, 0);
    reset = 1'b0;
    // single packet on channel 1
    push_pkt(1, 8'd3, 8'h11, 8'h11);
    w0 = wr_cnt; run = 0; mrun = 0; pd = 0;
    req[1] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        chk("t1_grant", {28'h0, grant}, 4'b0010);
        req[1] = 1'b0;
        req_len[15:8] = 8'd9;
      end
      @(negedge clk);
      run = wr_n ? 0 : run + 1;
      mrun = run > mrun ? run : mrun;
      if (pkt_done) begin
        pd++;
        chk("t1_grant_clr", {28'h0, grant}, 0);
      end
    end
    chk("t1_run", mrun, 5);
    chk("t1_done_cnt", pd, 1);
    chk("t1_bytes", wr_cnt - w0, 5);
    chk("t1_idle", {31'h0, busy}, 0);
    // TXE# stall while 22 is held
    @(posedge clk);
    #1;
    push_pkt(1, 8'd3, 8'h11, 8'h11);
    req[1] = 1'b1;
    for (int i = 0; i < 20 && data_out !== 8'h22; i++) begin
      @(posedge clk);
      #1;
      if (grant[1]) req[1] = 1'b0;
    end
    chk("t2_sync", {24'h0, data_out}, 8'h22);
    txe_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_wr_n_hi", {31'h0, wr_n}, 1);
      chk("t2_hold", {24'h0, data_out}, 8'h22);
      chk("t2_s_ready", {31'h0, s_ready[1]}, 0);
      @(posedge clk);
    end
    #1;
    txe_n = 1'b0;
    wait_done("t2_done");
    repeat (3) @(posedge clk);
    #1;
    // round robin with all four requesting
    for (int c = 0; c < N; c++) for (int k = 0; k < 16; k++) pay[c][k] = 8'hC0 + 8'(c);
    for (int p = 0; p < 8; p++) push_pkt((p + 2) % 4, 8'd1, 8'hC0 + 8'((p + 2) % 4), 8'd0);
    g0 = gcnt;
    req = '1;
    for (int p = 0; p < 8; p++) begin
      wait_done("rr_done");
      if (p == 7) req = '0;
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) chk("rr_count", gcnt[c] - g0[c], 2);
    // zero-length packet on channel 2
    push_pkt(2, 8'd0, 8'h00, 8'h00);
    w0 = wr_cnt; r0 = rdy_cnt;
    req[2] = 1'b1;
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    wait_done("z_done");
    chk("z_grant_clr", {28'h0, grant}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("z_bytes", wr_cnt - w0, 2);
    chk("z_s_ready", rdy_cnt - r0, 0);
    chk("z_idle", {31'h0, busy}, 0);
    // reset in the middle of a channel 3 payload
    push_pkt(3, 8'd5, 8'h41, 8'h01);
    req[3] = 1'b1;
    for (int i = 0; i < 20 && data_out !== 8'h42; i++) begin
      @(posedge clk);
      #1;
      if (grant[3]) req[3] = 1'b0;
    end
    chk("rs_sync", {24'h0, data_out}, 8'h42);
    reset = 1'b1;
    #1;
    chk("rs_wr_n", {31'h0, wr_n}, 1);
    chk("rs_grant", {28'h0, grant}, 0);
    chk("rs_busy", {31'h0, busy}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push_pkt(0, 8'd2, 8'h51, 8'h01);
    req = '1;
    @(posedge clk);
    #1;
    chk("rs_first", {28'h0, grant}, 4'b0001);
    req = '0;
    wait_done("rs_done");
    repeat (3) @(posedge clk);
    #1;
    // source stall of three cycles on channel 3
    push_pkt(3, 8'd4, 8'h31, 8'h01);
    w0 = wr_cnt;
    req[3] = 1'b1;
    for (int i = 0; i < 20 && data_out !== 8'h32; i++) begin
      @(posedge clk);
      #1;
      if (grant[3]) req[3] = 1'b0;
    end
    chk("st_sync", {24'h0, data_out}, 8'h32);
    sv_en[3] = 1'b0;
    @(negedge clk);
    chk("st_last_wr", {31'h0, wr_n}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("st_gap1", {31'h0, wr_n}, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("st_gap2", {31'h0, wr_n}, 1);
    @(posedge clk);
    #1;
    sv_en[3] = 1'b1;
    @(negedge clk);
    chk("st_gap3", {31'h0, wr_n}, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("st_resume", {31'h0, wr_n}, 0);
    wait_done("st_done");
    repeat (3) @(posedge clk);
    #1;
    chk("st_bytes", wr_cnt - w0, 6);
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
